// File: rtl/dmem_arbiter_46.sv
// ============================================================================
//  Module      : dmem_arbiter_46
//  Description : Single-port data memory arbiter, MEM stage (A) vs burst DMA (B)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter_46 #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STRIDE     = 4,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk_46,
   input  logic          rst_46,
   // port A: pipeline MEM stage
   input  logic          a_req_46,
   input  logic          a_we_46,
   input  logic [AW-1:0] a_addr_46,
   input  logic [DW-1:0] a_wdata_46,
   output logic          a_gnt_46,
   output logic [DW-1:0] a_rdata_46,
   output logic          stall_46,
   // port B: burst engine
   input  logic          b_start_46,
   input  logic          b_we_46,
   input  logic [AW-1:0] b_base_46,
   input  logic [7:0]    b_len_46,
   input  logic [DW-1:0] b_wdata_46,
   output logic          b_wready_46,
   output logic [DW-1:0] b_rdata_46,
   output logic          b_rvalid_46,
   output logic          b_busy_46,
   output logic          b_done_46,
   // memory side
   output logic [AW-1:0] m_waddr_46,
   output logic [DW-1:0] m_wdata_46,
   output logic          m_write_46,
   output logic [AW-1:0] m_raddr_46,
   input  logic [DW-1:0] m_rdata_46
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] C_STARVE_LIM = SW'(STARVE_LIM);
   localparam logic [AW-1:0] C_STRIDE     = AW'(STRIDE);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cur_q, cur_d;
   logic [7:0]    rem_q, rem_d;
   logic          we_q, we_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          a_win;
   logic          b_slot;

   // Slot ownership. B is held off while reset is asserted so a reset that
   // lands mid-burst cannot issue one more memory write.
   always_comb begin
      a_win  = 1'b0;
      b_slot = 1'b0;
      if (state_q == ST_BURST && !rst_46) begin
         if (a_req_46 && (starve_q < C_STARVE_LIM)) begin
            a_win = 1'b1;
         end else begin
            b_slot = 1'b1;
         end
      end else begin
         a_win = a_req_46;
      end
   end

   always_comb begin
      a_gnt_46    = a_win;
      stall_46    = a_req_46 & ~a_win;
      b_wready_46 = b_slot & we_q;
      m_write_46  = 1'b0;
      m_waddr_46  = '0;
      m_raddr_46  = '0;
      m_wdata_46  = '0;
      a_rdata_46  = '0;
      if (a_win) begin
         m_write_46 = a_we_46;
         m_waddr_46 = a_addr_46;
         m_raddr_46 = a_addr_46;
         m_wdata_46 = a_wdata_46;
         a_rdata_46 = a_we_46 ? '0 : m_rdata_46;
      end else if (b_slot) begin
         m_write_46 = we_q;
         m_waddr_46 = cur_q;
         m_raddr_46 = cur_q;
         m_wdata_46 = b_wdata_46;
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      rem_d    = rem_q;
      we_d     = we_q;
      starve_d = starve_q;
      done_d   = 1'b0;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            starve_d = '0;
            if (b_start_46) begin
               cur_d = b_base_46;
               rem_d = b_len_46;
               we_d  = b_we_46;
               if (b_len_46 == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_BURST;
               end
            end
         end
         ST_BURST: begin
            if (b_slot) begin
               starve_d = '0;
               cur_d    = cur_q + C_STRIDE;
               rem_d    = rem_q - 8'd1;
               if (!we_q) begin
                  rvalid_d = 1'b1;
                  rdata_d  = m_rdata_46;
               end
               if (rem_q == 8'd1) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (a_win) begin
               starve_d = starve_q + SW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_BURST);
   end

   always_ff @(posedge clk_46) begin
      if (rst_46) begin
         state_q  <= ST_IDLE;
         cur_q    <= '0;
         rem_q    <= '0;
         we_q     <= 1'b0;
         starve_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         rem_q    <= rem_d;
         we_q     <= we_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign b_busy_46   = busy_q;
   assign b_done_46   = done_q;
   assign b_rvalid_46 = rvalid_q;
   assign b_rdata_46  = rdata_q;

endmodule

`default_nettype wire
